// File: rtl/bus_arb_rr.sv
// rtl/bus_arb_rr.sv - four-master round-robin bus arbiter with hold preemption and stall timeout
module bus_arb_rr #(
  parameter int TIMEOUT_CYC = 255,
  parameter int MAX_HOLD    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] m_req,
  input  logic       m_as,
  input  logic       s_ready,
  output logic [3:0] m_get,
  output logic [1:0] owner,
  output logic       grant_vld,
  output logic       bus_err,
  output logic [1:0] err_master
);

  typedef enum logic [1:0] {IDLE, GRANT, ERR} state_t;

  localparam logic [9:0] STALL_LIM = 10'(TIMEOUT_CYC - 1);
  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);

  state_t     state, state_nxt;
  logic [3:0] m_get_nxt;
  logic [1:0] owner_nxt, last, last_nxt, err_master_nxt;
  logic       bus_err_nxt;
  logic [7:0] hold_cnt, hold_nxt, hold_inc;
  logic [9:0] stall_cnt, stall_nxt;
  logic [1:0] sel, cand;
  logic       found;
  logic       stalled, xfer, owner_req, others_req, timeout, preempt;

  // Search starts one past the last winner; the last winner itself is checked last.
  always_comb begin
    sel   = last;
    found = 1'b0;
    cand  = last;
    for (int i = 1; i <= 4; i++) begin
      cand = last + i[1:0];
      if (!found && m_req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign stalled    = m_as & ~s_ready;
  assign xfer       = m_as & s_ready;
  assign owner_req  = |(m_req & m_get);
  assign others_req = |(m_req & ~m_get);
  assign timeout    = stalled && (stall_cnt == STALL_LIM);
  assign preempt    = (hold_cnt == HOLD_MAX) && others_req;
  assign hold_inc   = (xfer && hold_cnt != HOLD_MAX) ? hold_cnt + 8'd1 : hold_cnt;
  assign grant_vld  = |m_get;

  always_comb begin
    state_nxt      = state;
    m_get_nxt      = m_get;
    owner_nxt      = owner;
    last_nxt       = last;
    bus_err_nxt    = 1'b0;
    err_master_nxt = err_master;
    hold_nxt       = hold_cnt;
    stall_nxt      = stall_cnt;
    case (state)
      IDLE: begin
        hold_nxt  = 8'd0;
        stall_nxt = 10'd0;
        if (found) begin
          state_nxt = GRANT;
          m_get_nxt = 4'b0001 << sel;
          owner_nxt = sel;
          last_nxt  = sel;
        end
      end
      GRANT: begin
        hold_nxt = hold_inc;
        if (timeout) begin
          state_nxt      = ERR;
          m_get_nxt      = 4'b0000;
          bus_err_nxt    = 1'b1;
          err_master_nxt = owner;
          stall_nxt      = 10'd0;
        end else if (!owner_req || preempt) begin
          state_nxt = IDLE;
          m_get_nxt = 4'b0000;
          stall_nxt = 10'd0;
        end else begin
          stall_nxt = stalled ? stall_cnt + 10'd1 : 10'd0;
        end
      end
      ERR: begin
        state_nxt = IDLE;
        stall_nxt = 10'd0;
      end
      default: begin
        state_nxt = IDLE;
        m_get_nxt = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      m_get      <= 4'b0000;
      owner      <= 2'd0;
      last       <= 2'd3;
      bus_err    <= 1'b0;
      err_master <= 2'd0;
      hold_cnt   <= 8'd0;
      stall_cnt  <= 10'd0;
    end else begin
      state      <= state_nxt;
      m_get      <= m_get_nxt;
      owner      <= owner_nxt;
      last       <= last_nxt;
      bus_err    <= bus_err_nxt;
      err_master <= err_master_nxt;
      hold_cnt   <= hold_nxt;
      stall_cnt  <= stall_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arb_rr.sv
// tb/tb_bus_arb_rr.sv - directed scoreboard bench for bus_arb_rr
module tb_bus_arb_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] m_req;
  logic       m_as;
  logic       s_ready;
  logic [3:0] m_get;
  logic [1:0] owner;
  logic       grant_vld;
  logic       bus_err;
  logic [1:0] err_master;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  bus_arb_rr dut (
    .clk        (clk),
    .rst        (rst),
    .m_req      (m_req),
    .m_as       (m_as),
    .s_ready    (s_ready),
    .m_get      (m_get),
    .owner      (owner),
    .grant_vld  (grant_vld),
    .bus_err    (bus_err),
    .err_master (err_master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after the coming edge are queued with the stimulus, then popped once the DUT has clocked.
  task automatic step(input string tag, input logic [3:0] get, input logic [1:0] own, input logic err);
    exp_t e;
    exp_t got;
    logic [7:0] obs;
    e.tag = tag;
    e.val = {get, own, |get, err};
    sb.push_back(e);
    tick();
    obs = {m_get, owner, grant_vld, bus_err};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%0h expected=scoreboard_entry", tag, obs);
    end else begin
      got = sb.pop_front();
      assert (obs === got.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", got.tag, obs, got.val);
      end
    end
  endtask

  initial begin
    int idx;
    rst = 1'b0; m_req = 4'b0000; m_as = 1'b0; s_ready = 1'b0;
    tick();
    step("reset", 4'b0000, 2'd0, 1'b0);
    check_val("reset_err_master", 10'(err_master), 10'd0);
    check_val("reset_last", 10'(dut.last), 10'd3);

    // Single master 1 grant, held then dropped
    rst = 1'b1;
    step("idle_after_reset", 4'b0000, 2'd0, 1'b0);
    m_req = 4'b0010;
    step("grant_m1", 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) step("hold_m1", 4'b0010, 2'd1, 1'b0);
    m_req = 4'b0000;
    step("drop_m1", 4'b0000, 2'd1, 1'b0);

    // Round robin from reset, one transfer per tenure
    rst = 1'b0;
    step("reset2", 4'b0000, 2'd0, 1'b0);
    check_val("reset2_last", 10'(dut.last), 10'd3);
    rst = 1'b1;
    step("idle2", 4'b0000, 2'd0, 1'b0);
    m_as = 1'b1; s_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idx = k % 4;
      m_req = 4'b1111;
      step("rr_grant", 4'b0001 << idx, 2'(idx), 1'b0);
      m_req = 4'b1111 & ~(4'b0001 << idx);
      step("rr_dead", 4'b0000, 2'(idx), 1'b0);
    end

    // Preemption of master 0 by master 2 after MAX_HOLD transfers
    m_req = 4'b0001;
    step("pre_grant_m0", 4'b0001, 2'd0, 1'b0);
    m_req = 4'b0101;
    for (int i = 0; i < 8; i++) step("pre_hold_m0", 4'b0001, 2'd0, 1'b0);
    step("pre_release", 4'b0000, 2'd0, 1'b0);
    step("pre_grant_m2", 4'b0100, 2'd2, 1'b0);
    m_req = 4'b0000; m_as = 1'b0;
    step("pre_drop_m2", 4'b0000, 2'd2, 1'b0);

    // Lone master 1 keeps the bus, hold count saturates
    m_req = 4'b0010; m_as = 1'b1; s_ready = 1'b1;
    step("sat_grant_m1", 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 12; i++) step("sat_hold_m1", 4'b0010, 2'd1, 1'b0);
    check_val("sat_hold_cnt", 10'(dut.hold_cnt), 10'd8);
    m_req = 4'b0000;
    step("sat_drop_m1", 4'b0000, 2'd1, 1'b0);

    // Timeout of master 3: 254 stalls tolerated, 255th releases with bus_err
    m_req = 4'b1000; s_ready = 1'b0;
    step("to_grant_m3", 4'b1000, 2'd3, 1'b0);
    for (int i = 0; i < 254; i++) step("to_stall", 4'b1000, 2'd3, 1'b0);
    step("to_err", 4'b0000, 2'd3, 1'b1);
    check_val("to_err_master", 10'(err_master), 10'd3);
    step("to_err_cycle", 4'b0000, 2'd3, 1'b0);
    check_val("to_err_master_held", 10'(err_master), 10'd3);
    step("to_regrant_m3", 4'b1000, 2'd3, 1'b0);
    m_req = 4'b0000; m_as = 1'b0;
    step("to_drop_m3", 4'b0000, 2'd3, 1'b0);

    // Owner drop coinciding with timeout: timeout wins
    m_req = 4'b0001; m_as = 1'b1; s_ready = 1'b0;
    step("tod_grant_m0", 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 254; i++) step("tod_stall", 4'b0001, 2'd0, 1'b0);
    m_req = 4'b0000;
    step("tod_err", 4'b0000, 2'd0, 1'b1);
    check_val("tod_err_master", 10'(err_master), 10'd0);
    m_as = 1'b0;
    step("tod_err_cycle", 4'b0000, 2'd0, 1'b0);

    // Reset mid-grant of master 2
    m_req = 4'b0100;
    step("rg_grant_m2", 4'b0100, 2'd2, 1'b0);
    step("rg_hold_m2", 4'b0100, 2'd2, 1'b0);
    rst = 1'b0;
    step("rg_reset", 4'b0000, 2'd0, 1'b0);
    check_val("rg_last", 10'(dut.last), 10'd3);
    rst = 1'b1; m_req = 4'b0000;
    step("rg_idle", 4'b0000, 2'd0, 1'b0);
    m_req = 4'b0101; m_as = 1'b1; s_ready = 1'b1;
    step("rg_grant_m0", 4'b0001, 2'd0, 1'b0);

    // Owner drop coinciding with preemption: single release, no bus_err
    for (int i = 0; i < 8; i++) step("pd_hold_m0", 4'b0001, 2'd0, 1'b0);
    m_req = 4'b0100;
    step("pd_release", 4'b0000, 2'd0, 1'b0);
    step("pd_grant_m2", 4'b0100, 2'd2, 1'b0);
    m_req = 4'b0000; m_as = 1'b0;
    step("pd_drop_m2", 4'b0000, 2'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arb_rr.md
BUS_ARB_RR -- requirements
Module: bus_arb_rr

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: consecutive stalled cycles (m_as=1, s_ready=0) before forced release; legal range 2..1023.
REQ-002 Parameter MAX_HOLD, default 8: completed transfers after which the owner is preempted if another master is requesting; legal range 1..255.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 m_req  input  4  bus request, bit n = master n (m0_req..m3_req).
REQ-006 m_as  input  1  address strobe of the currently muxed master.
REQ-007 s_ready  input  1  ready of the selected slave; completes a transfer when m_as=1.
REQ-008 m_get  output  4  one-hot grant, bit n = master n (m0_get..m3_get); registered.
REQ-009 owner  output  2  index of granted master; valid only while grant_vld=1.
REQ-010 grant_vld  output  1  high while any m_get bit is high.
REQ-011 bus_err  output  1  one-cycle pulse on timeout release.
REQ-012 err_master  output  2  index of master released by timeout; held until next timeout.

Function
REQ-013 States: IDLE, GRANT, ERR; state, m_get, owner and all counters registered.
REQ-014 IDLE: if m_req!=0 at edge t, m_get = one-hot of selected master and state = GRANT from t+1; else stay IDLE, m_get=0.
REQ-015 Selection: round-robin from pointer last; search order last+1, last+2, last+3, last (mod 4); first requesting master wins.
REQ-016 last is updated to the selected index at each grant.
REQ-017 GRANT: m_get held constant; m_req bits of non-owners ignored except for preemption check.
REQ-018 GRANT, owner's m_req=0 at edge t: m_get=0, state IDLE at t+1; re-arbitration in IDLE, next grant no earlier than t+2 (one mandatory dead cycle).
REQ-019 Transfer count hold_cnt (8 bits): cleared on entry to GRANT; increments on each cycle with m_as=1 and s_ready=1.
REQ-020 Preemption: in GRANT, if hold_cnt==MAX_HOLD and (m_req & ~m_get)!=0, release as in REQ-018 even if owner still requests.
REQ-021 If hold_cnt==MAX_HOLD and no other request, hold_cnt saturates at MAX_HOLD; owner keeps the bus.
REQ-022 Stall counter stall_cnt (10 bits): increments each GRANT cycle with m_as=1, s_ready=0; cleared when m_as=0, s_ready=1, or leaving GRANT.
REQ-023 Timeout: when stall_cnt reaches TIMEOUT_CYC-1 and the current cycle is still stalled, next edge: state ERR, m_get=0, bus_err=1, err_master=owner.
REQ-024 ERR: lasts exactly one cycle, bus_err deasserts, state -> IDLE unconditionally; timed-out master eligible again only through normal round-robin (it becomes last).
REQ-025 Simultaneous owner-drop and timeout in the same cycle: timeout wins (bus_err pulses).
REQ-026 Simultaneous owner-drop and preemption: release once, no bus_err.
REQ-027 A transfer completing (s_ready=1) in the same cycle the owner drops m_req is counted and released normally.
REQ-028 grant_vld = |m_get; owner holds last granted index when grant_vld=0.

Reset
REQ-029 While rst=0 at an edge: state IDLE, m_get=0, grant_vld=0, owner=0, bus_err=0, err_master=0, hold_cnt=0, stall_cnt=0, last=3 (master 0 first).
REQ-030 Reset asserted mid-GRANT drops m_get at the next edge; no bus_err is generated by reset.
REQ-031 First grant possible on the edge after the first edge with rst=1.

Verification
REQ-032 Reset released, m_req=4'b1111 held, owner drops req after 1 transfer each -> grants 0,1,2,3,0 with one dead cycle between each.
REQ-033 m_req=4'b0010 at edge t from IDLE -> m_get=4'b0010, owner=1 at t+1; drop req at t+5 -> m_get=0 at t+6.
REQ-034 Master 0 holds req with continuous m_as=1,s_ready=1, master 2 requests -> after 8 transfers m_get=0 one cycle, then m_get=4'b0100.
REQ-035 Master 3 granted, m_as=1, s_ready=0 for 255 cycles -> bus_err=1 one cycle, err_master=3, m_get=0, then IDLE; with TIMEOUT_CYC=255 no pulse at 254 stalled cycles.
REQ-036 Master 1 alone holds req with transfers >8 -> no preemption, m_get stays 4'b0010, hold_cnt saturates at 8.
REQ-037 rst=0 for one edge during GRANT of master 2 -> m_get=0, last=3; next request set 4'b0101 grants master 0.
